uart_periph: RTL and testbench
==============================

UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, meaning clk cycles per UART bit (50 MHz / 9600); legal range 4..65535.
REQ-002 SHALL have parameter BASE, default 32'h40000018, meaning the address of the first of three word registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port MemRd  input  1  bus read strobe, qualified by Addr.
REQ-006 SHALL have port MemWr  input  1  bus write strobe, qualified by Addr.
REQ-007 SHALL have port Addr  input  32  byte address; only full-word matches decode.
REQ-008 SHALL have port WriteData  input  32  bus write data.
REQ-009 SHALL have port ReadData  output  32  combinational read data; 0 when not reading a decoded register.
REQ-010 SHALL have port UART_RX  input  1  asynchronous serial input, idle high.
REQ-011 SHALL have port UART_TX  output  1  serial output, idle high.
REQ-012 SHALL have port uart_irq  output  1  level interrupt to the processor.

Function
REQ-013 SHALL decode the registers as: BASE = TXD (write [7:0] starts TX), BASE+4 = RXD (read [7:0] returns the last received byte), BASE+8 = CON.
REQ-014 SHALL define CON bits: [0] tx_ie (R/W), [1] rx_ie (R/W), [2] rx_done (RO), [3] tx_done (RO), [4] tx_busy (RO), [5] frame_err (RO), [6] overrun (RO); bits [31:7] read 0.
REQ-015 SHALL drive uart_irq = (tx_ie & tx_done) | (rx_ie & rx_done) as a combinational output from registered state.
REQ-016 SHALL, when a CON read occurs at a clock edge, clear tx_done, frame_err and overrun; rx_done SHALL clear only on an RXD read.
REQ-017 SHALL give a set event priority over a clear event for the same flag in the same cycle.
REQ-018 SHALL have a TX FSM with states IDLE, START, DATA, STOP, each bit lasting exactly BAUD_DIV cycles, data sent LSB first.
REQ-019 SHALL, on a TXD write while in IDLE, latch WriteData[7:0], set tx_busy and enter START on the next edge, so that UART_TX goes low one cycle after the write.
REQ-020 SHALL ignore a TXD write while tx_busy=1, including the final STOP cycle; no queueing.
REQ-021 SHALL, at the end of STOP, return to IDLE, clear tx_busy and set tx_done; the frame occupies 10*BAUD_DIV cycles.
REQ-022 SHALL pass UART_RX through a 2-flop synchronizer before any use.
REQ-023 SHALL have an RX FSM with states IDLE, START, DATA, STOP.
REQ-024 SHALL, in RX IDLE, enter START on a synchronized high-to-low transition.
REQ-025 SHALL, in RX START, sample at BAUD_DIV/2 (integer division); if the sample is high, treat it as a false start and return to IDLE with no flags changed.
REQ-026 SHALL, in RX DATA, sample 8 bits each BAUD_DIV cycles after the mid-start sample, shifting LSB first.
REQ-027 SHALL, in RX STOP, sample once: if high, load RXD and set rx_done, and also set overrun if rx_done was already 1 (the new byte overwrites); if low, set frame_err, leave RXD and rx_done unchanged, and wait for line high before returning to IDLE.
REQ-028 SHALL run RX and TX fully independently; simultaneous events on the bus, RX and TX SHALL all take effect in the same cycle.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, force both FSMs to IDLE, zero all counters, CON, TXD latch and RXD, and set the synchronizer flops to 1.
REQ-030 SHALL, in the cycle after reset, present UART_TX=1, uart_irq=0 and ReadData=0 for every address.
REQ-031 SHALL abort any frame in progress when reset is asserted, with no flags set by the aborted frame.

Verification (BAUD_DIV=8 for all)
REQ-032 Write TXD=0x55 -> UART_TX shows 0 then 1,0,1,0,1,0,1,0, then 1, each for 8 cycles; tx_done=1 at cycle 81; a CON read returns 0x08 and a following read returns 0x00.
REQ-033 Drive the RX frame for 0xA3 with rx_ie=1 -> uart_irq rises after the stop sample; RXD reads 0xA3; uart_irq falls the cycle after the RXD read.
REQ-034 Apply an RX low glitch of 3 cycles -> no flag set, and the FSM is back in IDLE by cycle 8.
REQ-035 Send 0x11 then 0x22 without reading RXD -> RXD=0x22, CON reads 0x44, and the next CON read shows overrun=0.
REQ-036 Drive an RX frame with stop bit = 0 -> frame_err=1, rx_done=0, RXD unchanged; write TXD during busy -> output frame unchanged.
REQ-037 Assert reset mid-TX frame -> UART_TX=1 and CON=0 on the next cycle, and no tx_done afterwards.

Source files
------------

// File: rtl/uart_periph.sv
// Memory-mapped UART peripheral: TXD/RXD/CON word registers, 8N1 framing,
// independent TX and RX state machines, level interrupt.
module uart_periph #(
  parameter int          BAUD_DIV = 5208,
  parameter logic [31:0] BASE     = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        uart_irq
);

  localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode
  logic sel_txd, sel_rxd, sel_con;
  logic tx_wr, con_wr, con_rd, rxd_rd;
  assign sel_txd = (Addr == BASE);
  assign sel_rxd = (Addr == (BASE + 32'd4));
  assign sel_con = (Addr == (BASE + 32'd8));
  assign tx_wr   = MemWr & sel_txd;
  assign con_wr  = MemWr & sel_con;
  assign con_rd  = MemRd & sel_con;
  assign rxd_rd  = MemRd & sel_rxd;

  // Upper write-data bits are not used by any register
  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  // Control/status state
  logic tx_ie, rx_ie, rx_done, tx_done, tx_busy, frame_err, overrun;
  logic [7:0] rxd;

  // ---------------- TX ----------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_out;
  logic        tx_tick, tx_go, tx_finish;

  assign tx_tick = (tx_cnt == DIV_LAST);

  // TX next-state logic; a write is only accepted from IDLE
  always_comb begin
    tx_next   = tx_state;
    tx_go     = 1'b0;
    tx_finish = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_next = TX_START;
          tx_go   = 1'b1;
        end else begin
          tx_next = TX_IDLE;
        end
      end
      TX_START: if (tx_tick) tx_next = TX_DATA; else tx_next = TX_START;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = TX_STOP; else tx_next = TX_DATA;
      TX_STOP: begin
        if (tx_tick) begin
          tx_next   = TX_IDLE;
          tx_finish = 1'b1;
        end else begin
          tx_next = TX_STOP;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX state register, bit timer, shifter and registered line output
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_next;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= 16'd0;
          tx_bit <= 3'd0;
          if (tx_wr) begin
            tx_shift <= WriteData[7:0];
            tx_out   <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt <= 16'd0;
            tx_out <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= 16'd0;
            if (tx_bit == 3'd7) begin
              tx_out <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_out   <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_tick) tx_cnt <= 16'd0;
          else         tx_cnt <= tx_cnt + 16'd1;
        end
        default: tx_cnt <= 16'd0;
      endcase
    end
  end

  assign UART_TX = tx_out;

  // ---------------- RX ----------------
  rx_state_t   rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_wait;
  logic        rx_tick, rx_good, rx_bad;

  assign rx_tick = (rx_cnt == DIV_LAST);

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= UART_RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX next-state logic and stop-bit outcome
  always_comb begin
    rx_next = rx_state;
    rx_good = 1'b0;
    rx_bad  = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s2) rx_next = RX_START; else rx_next = RX_IDLE;
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          if (rx_s2) rx_next = RX_IDLE;
          else       rx_next = RX_DATA;
        end else begin
          rx_next = RX_START;
        end
      end
      RX_DATA: if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP; else rx_next = RX_DATA;
      RX_STOP: begin
        if (rx_wait) begin
          // Framing error: hold until the line returns high
          if (rx_s2) rx_next = RX_IDLE;
          else       rx_next = RX_STOP;
        end else if (rx_tick) begin
          if (rx_s2) begin
            rx_good = 1'b1;
            rx_next = RX_IDLE;
          end else begin
            rx_bad  = 1'b1;
            rx_next = RX_STOP;
          end
        end else begin
          rx_next = RX_STOP;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // RX state register, bit timer, shifter and received-byte register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_wait  <= 1'b0;
      rxd      <= 8'd0;
    end else begin
      rx_state <= rx_next;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt  <= 16'd0;
          rx_bit  <= 3'd0;
          rx_wait <= 1'b0;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) rx_cnt <= 16'd0;
          else                     rx_cnt <= rx_cnt + 16'd1;
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= 16'd0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (!rx_wait) begin
            if (rx_tick) begin
              rx_cnt <= 16'd0;
              if (rx_s2) rxd     <= rx_shift;
              else       rx_wait <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 16'd1;
            end
          end
        end
        default: rx_cnt <= 16'd0;
      endcase
    end
  end

  // Status flags: a set in the same cycle wins over a read-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ie     <= 1'b0;
      rx_ie     <= 1'b0;
      rx_done   <= 1'b0;
      tx_done   <= 1'b0;
      tx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_ie <= WriteData[0];
        rx_ie <= WriteData[1];
      end
      if (tx_go)          tx_busy <= 1'b1;
      else if (tx_finish) tx_busy <= 1'b0;
      tx_done   <= tx_finish | (tx_done & ~con_rd);
      rx_done   <= rx_good | (rx_done & ~rxd_rd);
      frame_err <= rx_bad | (frame_err & ~con_rd);
      overrun   <= (rx_good & rx_done) | (overrun & ~con_rd);
    end
  end

  // Combinational read mux; zero unless a decoded register is read
  always_comb begin
    ReadData = 32'd0;
    if (MemRd && sel_rxd) begin
      ReadData = {24'd0, rxd};
    end else if (MemRd && sel_con) begin
      ReadData = {25'd0, overrun, frame_err, tx_busy, tx_done, rx_done, rx_ie, tx_ie};
    end else begin
      ReadData = 32'd0;
    end
  end

  assign uart_irq = (tx_ie & tx_done) | (rx_ie & rx_done);

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph with BAUD_DIV=8: frame-level reference
// model, per-cycle line check, directed scenarios and randomized traffic.
module tb_uart_periph;
  localparam int          BD   = 8;
  localparam logic [31:0] BASE = 32'h40000018;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] RXD  = BASE + 32'd4;
  localparam logic [31:0] CON  = BASE + 32'd8;

  logic clk = 1'b0;
  logic reset, MemRd, MemWr, UART_RX;
  logic [31:0] Addr, WriteData, ReadData;
  logic UART_TX, uart_irq;

  uart_periph #(.BAUD_DIV(BD), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .UART_RX(UART_RX),
    .UART_TX(UART_TX), .uart_irq(uart_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  // Reference model state (frame level)
  int         tx_w    = -1000;
  int         tx_kill = 1 << 30;
  logic [7:0] tx_byte = 8'd0;
  bit tx_done_m, rx_done_m, ferr_m, ovr_m, tx_ie_m, rx_ie_m;
  logic [7:0] rxd_m = 8'd0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_tx(input int m);
    int off;
    if (m >= tx_w && m < tx_w + 80 && m < tx_kill) begin
      off = m - tx_w;
      if (off < 8)        return 1'b0;
      else if (off >= 72) return 1'b1;
      else                return tx_byte[(off / 8) - 1];
    end
    return 1'b1;
  endfunction

  function automatic int tx_free();
    int a;
    a = tx_w + 81;
    if (tx_kill + 1 < a) a = tx_kill + 1;
    return a;
  endfunction

  // Per-cycle compare of the serial line and idle read data against the model
  always @(negedge clk) begin
    if (cyc == tx_w + 80 && cyc < tx_kill) tx_done_m = 1'b1;
    if (chk_en) begin
      check("uart_tx", {31'd0, UART_TX}, {31'd0, exp_tx(cyc)});
      if (!MemRd) check("rdata_idle", ReadData, 32'd0);
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int e;
    @(posedge clk); #1;
    MemWr = 1'b1; Addr = a; WriteData = d;
    e = cyc + 1;
    if (a == TXD && e >= tx_free()) begin
      tx_w = e; tx_kill = 1 << 30; tx_byte = d[7:0];
    end
    if (a == CON) begin
      tx_ie_m = d[0]; rx_ie_m = d[1];
    end
    @(posedge clk); #1;
    MemWr = 1'b0; Addr = 32'd0; WriteData = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int m);
    @(posedge clk); #1;
    MemRd = 1'b1; Addr = a;
    @(negedge clk);
    d = ReadData; m = cyc;
    @(posedge clk); #1;
    MemRd = 1'b0; Addr = 32'd0;
  endtask

  // Reads CON, compares to the model, applies read-clear to the model
  task automatic con_read(input string name, output logic [31:0] d);
    int m;
    logic busy, txd;
    bus_read(CON, d, m);
    busy = (m >= tx_w && m < tx_w + 80 && m < tx_kill);
    txd  = tx_done_m | (m == tx_w + 80 && m < tx_kill);
    check(name, d, {25'd0, ovr_m, ferr_m, busy, txd, rx_done_m, rx_ie_m, tx_ie_m});
    tx_done_m = 1'b0; ferr_m = 1'b0; ovr_m = 1'b0;
  endtask

  task automatic rxd_read(input string name, output logic [31:0] d);
    int m;
    bus_read(RXD, d, m);
    check(name, d, {24'd0, rxd_m});
    rx_done_m = 1'b0;
  endtask

  // Holds UART_RX at v for one bit time; called in the #1-after-edge phase
  task automatic rx_bit(input logic v);
    UART_RX = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
    @(posedge clk); #1;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop_ok);
    if (!stop_ok) rx_bit(1'b0);
    UART_RX = 1'b1;
    if (stop_ok) begin
      ovr_m = ovr_m | rx_done_m;
      rx_done_m = 1'b1;
      rxd_m = b;
    end else begin
      ferr_m = 1'b1;
    end
    repeat (2 * BD) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg_cycle(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_tx_quiet();
    while (cyc <= tx_w + 85) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic [9:0]  pat;
  logic [7:0]  b1, b2;
  bit          stop_ok;
  int          w0;

  initial begin
    reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Addr = 32'd0; WriteData = 32'd0; UART_RX = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    reset = 1'b0;

    // Reset state
    check("irq_after_reset", {31'd0, uart_irq}, 32'd0);
    begin
      int m;
      bus_read(TXD, rd, m); check("rd_txd_reset", rd, 32'd0);
      bus_read(RXD, rd, m); check("rd_rxd_reset", rd, 32'd0);
      bus_read(CON, rd, m); check("rd_con_reset", rd, 32'd0);
    end

    // TX 0x55: literal line pattern at mid-bit, busy mid-frame, done then cleared
    bus_write(TXD, 32'h55);
    w0  = tx_w;
    pat = 10'b1010101010;
    for (int k = 0; k < 10; k++) begin
      wait_neg_cycle(w0 + 8 * k + 4);
      check("tx55_bit", {31'd0, UART_TX}, {31'd0, pat[k]});
    end
    con_read("con_busy", rd);
    check("con_busy_lit", rd, 32'h10);
    wait_tx_quiet();
    con_read("con_txdone", rd);
    check("con_txdone_lit", rd, 32'h08);
    con_read("con_cleared", rd);
    check("con_cleared_lit", rd, 32'h00);

    // RX 0xA3 with rx_ie: interrupt up after the frame, down after RXD read
    bus_write(CON, 32'h2);
    check("irq_pre_rx", {31'd0, uart_irq}, 32'd0);
    rx_frame(8'hA3, 1'b1);
    check("irq_rx", {31'd0, uart_irq}, 32'd1);
    rxd_read("rxd_a3", rd);
    check("rxd_a3_lit", rd, 32'hA3);
    check("irq_after_rxd", {31'd0, uart_irq}, 32'd0);
    bus_write(CON, 32'h0);

    // 3-cycle glitch: no flags, receiver ready for the next frame shortly after
    @(posedge clk); #1;
    UART_RX = 1'b0;
    repeat (3) @(posedge clk);
    #1 UART_RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_frame(8'h3C, 1'b1);
    con_read("con_glitch", rd);
    check("con_glitch_lit", rd, 32'h04);
    rxd_read("rxd_3c", rd);

    // Overrun: two bytes without reading RXD
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    con_read("con_ovr", rd);
    check("con_ovr_lit", rd, 32'h44);
    con_read("con_ovr2", rd);
    check("con_ovr2_lit", rd, 32'h04);
    rxd_read("rxd_22", rd);
    check("rxd_22_lit", rd, 32'h22);

    // Framing error leaves RXD and rx_done alone
    rx_frame(8'h5A, 1'b0);
    con_read("con_ferr", rd);
    check("con_ferr_lit", rd, 32'h20);
    rxd_read("rxd_keep", rd);
    check("rxd_keep_lit", rd, 32'h22);

    // TXD write while busy is ignored (line checked every cycle)
    bus_write(TXD, 32'h0F);
    repeat (20) @(posedge clk);
    bus_write(TXD, 32'hF0);
    wait_tx_quiet();
    con_read("con_tx0f", rd);
    check("con_tx0f_lit", rd, 32'h08);

    // Reset mid-frame
    bus_write(TXD, 32'hC3);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    tx_kill = cyc + 1;
    tx_done_m = 1'b0; rx_done_m = 1'b0; ferr_m = 1'b0; ovr_m = 1'b0;
    tx_ie_m = 1'b0; rx_ie_m = 1'b0; rxd_m = 8'd0;
    @(posedge clk); #1 reset = 1'b0;
    check("tx_after_rst", {31'd0, UART_TX}, 32'd1);
    con_read("con_after_rst", rd);
    check("con_after_rst_lit", rd, 32'h00);
    repeat (100) @(posedge clk);
    con_read("con_no_txdone", rd);
    check("con_no_txdone_lit", rd, 32'h00);

    // Randomized concurrent TX/RX traffic
    for (int it = 0; it < 8; it++) begin
      bus_write(CON, $urandom_range(0, 3));
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      fork
        begin
          repeat ($urandom_range(0, 20)) @(posedge clk);
          bus_write(TXD, {24'd0, b1});
          repeat ($urandom_range(5, 70)) @(posedge clk);
          bus_write(TXD, $urandom);
        end
        begin
          repeat ($urandom_range(0, 30)) @(posedge clk);
          rx_frame(b2, stop_ok);
        end
      join
      wait_tx_quiet();
      check("irq_rand", {31'd0, uart_irq},
            {31'd0, (tx_ie_m & tx_done_m) | (rx_ie_m & rx_done_m)});
      con_read("con_rand", rd);
      if (rx_done_m) rxd_read("rxd_rand", rd);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
